// File: rtl/hi_xcorr_seq.sv
// Capture sequencer for the HF cross-correlation receive path: applies mode changes on
// correlator frame boundaries, blanks settling frames, then gates N I/Q frames to the SSP.
module hi_xcorr_seq #(
  parameter int SETTLE_FRAMES = 2,
  parameter int CNT_W         = 16,
  parameter int TIMEOUT       = 4096
) (
  input  logic             ck_1356meg,
  input  logic             nreset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_is_848,
  input  logic             cfg_quarter_freq,
  input  logic             cfg_snoop,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic             abort,
  input  logic             corr_phase_msb,
  output logic             xcorr_is_848,
  output logic             xcorr_quarter_freq,
  output logic             snoop,
  output logic             ssp_gate,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frames_left
);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int ST_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PEND, SETTLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic             sh_848_q, sh_848_d, sh_qf_q, sh_qf_d, sh_snoop_q, sh_snoop_d;
  logic [CNT_W-1:0] sh_frames_q, sh_frames_d;
  logic             m848_q, m848_d, mqf_q, mqf_d, msnoop_q, msnoop_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             terr_q, terr_d, gate_q, done_q;
  logic             frame_tick, wd_fire;

  // Falling edge of the counter MSB marks the 63->0 wrap of the correlator.
  assign frame_tick = prev_q & ~sync2_q;
  assign wd_fire    = (wd_q == WD_MAX) & ~frame_tick;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    sh_848_d    = sh_848_q;
    sh_qf_d     = sh_qf_q;
    sh_snoop_d  = sh_snoop_q;
    sh_frames_d = sh_frames_q;
    m848_d      = m848_q;
    mqf_d       = mqf_q;
    msnoop_d    = msnoop_q;
    left_d      = left_q;
    terr_d      = terr_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cfg_valid) begin
          sh_848_d    = cfg_is_848;
          sh_qf_d     = cfg_quarter_freq;
          sh_snoop_d  = cfg_snoop;
          sh_frames_d = cfg_frames;
          terr_d      = 1'b0;
          state_d     = PEND;
        end
        PEND: if (wd_fire || frame_tick) begin
          m848_d   = sh_848_q;
          mqf_d    = sh_qf_q;
          msnoop_d = sh_snoop_q;
          settle_d = ST_W'(SETTLE_FRAMES);
          if (wd_fire) terr_d = 1'b1;
          if (SETTLE_FRAMES == 0) begin
            left_d  = sh_frames_q;
            state_d = RUN;
          end else begin
            state_d = SETTLE;
          end
        end
        SETTLE: if (wd_fire) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end else if (frame_tick) begin
          settle_d = settle_q - ST_W'(1);
          if (settle_q == ST_W'(1)) begin
            left_d  = sh_frames_q;
            state_d = RUN;
          end
        end
        RUN: if (wd_fire) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end else if (frame_tick && left_q != '0) begin
          left_d = left_q - CNT_W'(1);
          if (left_q == CNT_W'(1)) state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Watchdog restarts on every boundary and every state transition.
  always_comb begin
    wd_d = wd_q;
    if (frame_tick || state_d != state_q) wd_d = '0;
    else if (wd_q != WD_MAX)              wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      wd_q        <= '0;
      settle_q    <= '0;
      sh_848_q    <= 1'b0;
      sh_qf_q     <= 1'b0;
      sh_snoop_q  <= 1'b0;
      sh_frames_q <= '0;
      m848_q      <= 1'b0;
      mqf_q       <= 1'b0;
      msnoop_q    <= 1'b0;
      left_q      <= '0;
      terr_q      <= 1'b0;
      gate_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= corr_phase_msb;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      wd_q        <= wd_d;
      settle_q    <= settle_d;
      sh_848_q    <= sh_848_d;
      sh_qf_q     <= sh_qf_d;
      sh_snoop_q  <= sh_snoop_d;
      sh_frames_q <= sh_frames_d;
      m848_q      <= m848_d;
      mqf_q       <= mqf_d;
      msnoop_q    <= msnoop_d;
      left_q      <= left_d;
      terr_q      <= terr_d;
      gate_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  assign cfg_ready          = (state_q == IDLE);
  assign busy               = ~cfg_ready;
  assign xcorr_is_848       = m848_q;
  assign xcorr_quarter_freq = mqf_q;
  assign snoop              = msnoop_q;
  assign ssp_gate           = gate_q;
  assign done               = done_q;
  assign timeout_err        = terr_q;
  assign frames_left        = left_q;
endmodule
